// File: rtl/atm_keypad_pkg.sv
// Shared key codes, entry modes and FSM state type for the ATM keypad front-end.
package atm_keypad_pkg;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    localparam logic MODE_PIN    = 1'b0;
    localparam logic MODE_AMOUNT = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_inactivity_timer.sv
// Inactivity down-counter: expired is asserted on the TIMEOUT_CYC-th enabled cycle after load.
module atm_inactivity_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] r_cnt;

    // Loading TIMEOUT_CYC-1 puts expiry on the TIMEOUT_CYC-th cycle after the load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CW'(TIMEOUT_CYC - 1);
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = enable && (r_cnt == '0);

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry front-end: collects a BCD PIN or a saturating decimal amount and
// hands it to the controller over a valid/ready handshake.
module atm_keypad_entry
    import atm_keypad_pkg::*;
#(
    parameter int unsigned PIN_DIGITS  = 4,
    parameter int unsigned AMT_DIGITS  = 5,
    parameter int unsigned AMT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    entry_start,
    input  logic                    entry_mode,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_amount,
    output logic [4*PIN_DIGITS-1:0] pin_out,
    output logic [AMT_W-1:0]        amount_out,
    output logic [2:0]              digit_count,
    output logic                    busy,
    output logic                    entry_error,
    output logic                    cancel_pulse,
    output logic                    timeout_pulse
);

    localparam int unsigned PIN_W  = 4 * PIN_DIGITS;
    localparam int unsigned AMT_XW = AMT_W + 4;
    localparam logic [AMT_XW-1:0] AMT_MAX = {4'b0000, {AMT_W{1'b1}}};

    state_t             r_state, w_state_d;
    logic               r_mode, w_mode_d;
    logic [PIN_W-1:0]   r_pin, w_pin_d;
    logic [AMT_W-1:0]   r_amt, w_amt_d;
    logic [2:0]         r_cnt, w_cnt_d;
    logic               r_out_valid, w_valid_d;
    logic               r_busy;
    logic               r_err, w_err_d;
    logic               r_cancel, w_cancel_d;
    logic               r_timeout, w_timeout_d;
    logic               w_wipe;
    logic               w_enter_ok;
    logic [AMT_XW-1:0]  w_amt_nxt;
    logic               w_tmr_load, w_tmr_en, w_tmr_expired;

    assign w_tmr_load = ((r_state == IDLE) && entry_start) || ((r_state == COLLECT) && key_valid);
    assign w_tmr_en   = (r_state == COLLECT);

    atm_inactivity_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_tmr_load),
        .enable  (w_tmr_en),
        .expired (w_tmr_expired)
    );

    // Wide enough that acc*10+d never wraps, so saturation is a plain compare.
    assign w_amt_nxt  = {4'b0000, r_amt} * AMT_XW'(10) + {{AMT_W{1'b0}}, key_code};
    assign w_enter_ok = (r_mode == MODE_PIN) ? (r_cnt == 3'(PIN_DIGITS)) : (r_amt != '0);

    always_comb begin
        w_state_d   = r_state;
        w_mode_d    = r_mode;
        w_pin_d     = r_pin;
        w_amt_d     = r_amt;
        w_cnt_d     = r_cnt;
        w_valid_d   = r_out_valid;
        w_err_d     = 1'b0;
        w_cancel_d  = 1'b0;
        w_timeout_d = 1'b0;
        w_wipe      = 1'b0;
        case (r_state)
            IDLE: begin
                if (entry_start) begin
                    w_state_d = COLLECT;
                    w_mode_d  = entry_mode;
                    w_wipe    = 1'b1;
                end
            end
            COLLECT: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (r_mode == MODE_PIN) begin
                            if (r_cnt < 3'(PIN_DIGITS)) begin
                                w_pin_d = {r_pin[PIN_W-5:0], key_code};
                                w_cnt_d = r_cnt + 3'd1;
                            end else begin
                                w_err_d = 1'b1;
                            end
                        end else if ((r_cnt < 3'(AMT_DIGITS)) && (w_amt_nxt <= AMT_MAX)) begin
                            w_amt_d = w_amt_nxt[AMT_W-1:0];
                            w_cnt_d = r_cnt + 3'd1;
                        end else begin
                            w_err_d = 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (w_enter_ok) begin
                            w_state_d = HOLD;
                            w_valid_d = 1'b1;
                        end else begin
                            w_err_d = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_wipe = 1'b1;
                    end else if (key_code == KEY_CANCEL) begin
                        w_state_d  = IDLE;
                        w_wipe     = 1'b1;
                        w_cancel_d = 1'b1;
                    end
                end else if (w_tmr_expired) begin
                    w_state_d   = IDLE;
                    w_wipe      = 1'b1;
                    w_timeout_d = 1'b1;
                end
            end
            HOLD: begin
                // A completed handshake takes priority over a simultaneous CANCEL.
                if (r_out_valid && out_ready) begin
                    w_state_d = IDLE;
                    w_valid_d = 1'b0;
                end else if (key_valid && (key_code == KEY_CANCEL)) begin
                    w_state_d  = IDLE;
                    w_valid_d  = 1'b0;
                    w_wipe     = 1'b1;
                    w_cancel_d = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_valid_d = 1'b0;
            end
        endcase
        if (w_wipe) begin
            w_pin_d = '0;
            w_amt_d = '0;
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_PIN;
            r_pin       <= '0;
            r_amt       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_cancel    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_mode      <= w_mode_d;
            r_pin       <= w_pin_d;
            r_amt       <= w_amt_d;
            r_cnt       <= w_cnt_d;
            r_out_valid <= w_valid_d;
            r_busy      <= (w_state_d != IDLE);
            r_err       <= w_err_d;
            r_cancel    <= w_cancel_d;
            r_timeout   <= w_timeout_d;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_is_amount = r_mode;
    assign pin_out       = r_pin;
    assign amount_out    = r_amt;
    assign digit_count   = r_cnt;
    assign busy          = r_busy;
    assign entry_error   = r_err;
    assign cancel_pulse  = r_cancel;
    assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: directed scenarios then random keystrokes, every cycle
// checked against a digit-queue reference model.
module tb_atm_keypad_entry;

    localparam int TMO = 20;

    logic        clk;
    logic        rst;
    logic        entry_start;
    logic        entry_mode;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        out_valid;
    logic        out_ready;
    logic        out_is_amount;
    logic [15:0] pin_out;
    logic [15:0] amount_out;
    logic [2:0]  digit_count;
    logic        busy;
    logic        entry_error;
    logic        cancel_pulse;
    logic        timeout_pulse;

    atm_keypad_entry #(
        .PIN_DIGITS  (4),
        .AMT_DIGITS  (5),
        .AMT_W       (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .entry_start   (entry_start),
        .entry_mode    (entry_mode),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_is_amount (out_is_amount),
        .pin_out       (pin_out),
        .amount_out    (amount_out),
        .digit_count   (digit_count),
        .busy          (busy),
        .entry_error   (entry_error),
        .cancel_pulse  (cancel_pulse),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 presenting; digits kept as a queue.
    int   m_phase;
    logic m_mode;
    int   q[$];
    int   m_idle;
    logic exp_err, exp_cancel, exp_to;

    function automatic int q_amount();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    function automatic int q_bcd();
        int v = 0;
        foreach (q[i]) v = v * 16 + q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_mode = 1'b0;
        q.delete();
        m_idle = 0;
        exp_err = 1'b0;
        exp_cancel = 1'b0;
        exp_to = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic m, input logic kv,
                              input logic [3:0] kc, input logic rdy);
        int d;
        d = int'(kc);
        exp_err = 1'b0;
        exp_cancel = 1'b0;
        exp_to = 1'b0;
        case (m_phase)
            0: begin
                if (s) begin
                    m_phase = 1;
                    m_mode = m;
                    q.delete();
                    m_idle = 0;
                end
            end
            1: begin
                if (kv) begin
                    m_idle = 0;
                    if (d <= 9) begin
                        if (!m_mode && q.size() < 4) q.push_back(d);
                        else if (m_mode && q.size() < 5 && q_amount() * 10 + d <= 65535)
                            q.push_back(d);
                        else exp_err = 1'b1;
                    end else if (d == 10) begin
                        if (m_mode ? (q_amount() != 0) : (q.size() == 4)) m_phase = 2;
                        else exp_err = 1'b1;
                    end else if (d == 11) begin
                        q.delete();
                    end else if (d == 12) begin
                        m_phase = 0;
                        q.delete();
                        exp_cancel = 1'b1;
                    end
                end else begin
                    m_idle++;
                    if (m_idle >= TMO) begin
                        m_phase = 0;
                        q.delete();
                        exp_to = 1'b1;
                    end
                end
            end
            default: begin
                if (rdy) begin
                    m_phase = 0;
                end else if (kv && d == 12) begin
                    m_phase = 0;
                    q.delete();
                    exp_cancel = 1'b1;
                end
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(m_phase == 2));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("out_is_amount", 32'(out_is_amount), 32'(m_mode));
        check("pin_out", 32'(pin_out), m_mode ? 32'd0 : 32'(q_bcd()));
        check("amount_out", 32'(amount_out), m_mode ? 32'(q_amount()) : 32'd0);
        check("digit_count", 32'(digit_count), 32'(q.size()));
        check("entry_error", 32'(entry_error), 32'(exp_err));
        check("cancel_pulse", 32'(cancel_pulse), 32'(exp_cancel));
        check("timeout_pulse", 32'(timeout_pulse), 32'(exp_to));
    endtask

    task automatic cyc(input logic s, input logic m, input logic kv,
                       input logic [3:0] kc, input logic rdy);
        entry_start = s;
        entry_mode = m;
        key_valid = kv;
        key_code = kc;
        out_ready = rdy;
        model_step(s, m, kv, kc, rdy);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic start(input logic m);
        cyc(1'b1, m, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic key(input logic [3:0] kc);
        cyc(1'b0, 1'b0, 1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic accept();
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    endtask

    // Reset raised between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        entry_start = 1'b0;
        key_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int r, p;
        logic s, mm, kv, rdy;
        logic [3:0] kc;

        rst = 1'b1;
        entry_start = 1'b0;
        entry_mode = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // PIN 1234 accepted
        start(1'b0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        key(4'hA);
        check("pin_1234", 32'(pin_out), 32'h1234);
        check("pin_valid", 32'(out_valid), 32'd1);
        accept();

        // Short PIN rejected, then completed; consumer stalls 10 cycles
        start(1'b0);
        key(4'h1); key(4'h2); key(4'h3);
        key(4'hA);
        check("short_pin_err", 32'(entry_error), 32'd1);
        key(4'h9);
        key(4'hA);
        check("pin_1239", 32'(pin_out), 32'h1239);
        idle(10);
        accept();

        // Amounts
        start(1'b1);
        key(4'h8); key(4'h0); key(4'hA);
        check("amount_80", 32'(amount_out), 32'd80);
        accept();
        start(1'b1);
        key(4'h6); key(4'h5); key(4'h5); key(4'h3); key(4'h6);
        check("amt_sat_err", 32'(entry_error), 32'd1);
        check("amt_6553", 32'(amount_out), 32'd6553);
        key(4'hC);
        start(1'b1);
        key(4'h6); key(4'h5); key(4'h5); key(4'h3); key(4'h5);
        key(4'hA);
        check("amt_65535", 32'(amount_out), 32'd65535);
        accept();

        // CLEAR then ENTER with zero amount
        start(1'b1);
        key(4'h7); key(4'h7); key(4'hB); key(4'hA);
        check("clear_enter_err", 32'(entry_error), 32'd1);
        key(4'hC);

        // CANCEL in HOLD, then CANCEL racing out_ready
        start(1'b0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hA);
        key(4'hC);
        check("hold_cancel", 32'(cancel_pulse), 32'd1);
        check("hold_cancel_pin", 32'(pin_out), 32'd0);
        start(1'b0);
        key(4'h5); key(4'h6); key(4'h7); key(4'h8); key(4'hA);
        cyc(1'b0, 1'b0, 1'b1, 4'hC, 1'b1);
        check("race_pin_kept", 32'(pin_out), 32'h5678);

        // Timeout, key at cycle 19, key coinciding with expiry
        start(1'b0);
        idle(TMO - 1);
        idle(1);
        check("timeout_at_20", 32'(timeout_pulse), 32'd1);
        start(1'b1);
        idle(TMO - 2);
        key(4'h2);
        idle(TMO);
        start(1'b0);
        idle(TMO - 1);
        key(4'h3);
        idle(3);
        key(4'hC);

        // start with a key in IDLE, start in COLLECT ignored, keys in IDLE ignored
        cyc(1'b1, 1'b1, 1'b1, 4'h5, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'h4, 1'b0);
        key(4'hC);
        key(4'h7);

        // Asynchronous reset mid-entry
        start(1'b0);
        key(4'h1); key(4'h2);
        async_reset();

        // Random keystrokes
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                idle(TMO + 1);
            end else begin
                s = ($urandom_range(0, 9) == 0) || (m_phase == 0 && $urandom_range(0, 2) == 0);
                mm = 1'($urandom_range(0, 1));
                kv = ($urandom_range(0, 9) < 7);
                p = $urandom_range(0, 99);
                if (p < 78) kc = 4'($urandom_range(0, 9));
                else if (p < 88) kc = 4'hA;
                else if (p < 92) kc = 4'hB;
                else if (p < 95) kc = 4'hC;
                else kc = 4'($urandom_range(13, 15));
                rdy = ($urandom_range(0, 99) < 35);
                cyc(s, mm, kv, kc, rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
